// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// start/done handshake; the core stalls on busy while the divide is in flight.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // ZERO gives divide-by-zero a single cycle so done lands one edge after acceptance
  typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  q_q, d_q, r_q;
  logic [CW-1:0] count_q;
  logic          busy_q, done_q, dbz_q;
  logic [N-1:0]  quotient_q, remainder_q;

  logic [N:0]    r_shift;
  logic          ge;
  logic [N-1:0]  r_d, q_d;

  // The partial remainder always stays below D, so N bits hold it; only the shifted
  // value needs the extra bit for the trial compare.
  always_comb begin
    r_shift = {r_q, q_q[N-1]};
    ge      = (r_shift >= {1'b0, d_q});
    r_d     = ge ? (r_shift[N-1:0] - d_q) : r_shift[N-1:0];
    q_d     = {q_q[N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            count_q <= '0;
            if (divisor != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ZERO;
            end
          end
        end
        RUN: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
          end
        end
        ZERO: begin
          state_q     <= DONE;
          done_q      <= 1'b1;
          quotient_q  <= '1;
          remainder_q <= q_q;
          dbz_q       <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (N=8 and exhaustive N=4 instances)
module tb_seq_divider;

  typedef struct {
    int         u;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic       start_s [2];
  logic [7:0] dvd_s   [2];
  logic [7:0] dvs_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] q_s     [2];
  logic [7:0] r_s     [2];
  logic       dz_s    [2];
  logic       done_prev [2];
  int         busy_cnt  [2];
  logic [7:0] last_q [2];
  logic [7:0] last_r [2];
  logic       last_dz [2];

  logic [7:0] q8, r8;
  logic [3:0] q4, r4;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.N(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .dividend(dvd_s[0]), .divisor(dvs_s[0]),
    .busy(busy_s[0]), .done(done_s[0]),
    .quotient(q8), .remainder(r8), .div_by_zero(dz_s[0])
  );

  seq_divider #(.N(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .dividend(dvd_s[1][3:0]), .divisor(dvs_s[1][3:0]),
    .busy(busy_s[1]), .done(done_s[1]),
    .quotient(q4), .remainder(r4), .div_by_zero(dz_s[1])
  );

  assign q_s[0] = q8;
  assign r_s[0] = r8;
  assign q_s[1] = {4'h0, q4};
  assign r_s[1] = {4'h0, r4};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int u, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int w;
    w = (u == 0) ? 8 : 4;
    e.u = u;
    if (b == 0) begin
      e.q   = (u == 0) ? 8'hFF : 8'h0F;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = w;
    end
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (busy_s[u]) busy_cnt[u]++;
      if (done_s[u]) begin
        check_eq("done_one_cycle", {31'd0, done_prev[u]}, 32'd0);
        if (sb.size() == 0 || sb[0].u != u) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("quotient", {24'd0, q_s[u]}, {24'd0, e.q});
          check_eq("remainder", {24'd0, r_s[u]}, {24'd0, e.r});
          check_eq("div_by_zero", {31'd0, dz_s[u]}, {31'd0, e.dz});
          check_eq("latency", cyc - e.acc, e.lat);
          last_q[u]  = e.q;
          last_r[u]  = e.r;
          last_dz[u] = e.dz;
        end
      end
      done_prev[u] <= done_s[u];
    end
  end

  task automatic wait_drain();
    int t = 0;
    #1;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b, input bit chk_busy);
    exp_t e;
    @(negedge clk);
    check_eq("hold_quotient", {24'd0, q_s[u]}, {24'd0, last_q[u]});
    check_eq("hold_remainder", {24'd0, r_s[u]}, {24'd0, last_r[u]});
    check_eq("hold_div_by_zero", {31'd0, dz_s[u]}, {31'd0, last_dz[u]});
    e = model(u, a, b);
    e.acc = cyc + 1;
    start_s[u] = 1'b1;
    dvd_s[u] = a;
    dvs_s[u] = b;
    busy_cnt[u] = 0;
    sb.push_back(e);
    @(negedge clk);
    start_s[u] = 1'b0;
    dvd_s[u] = 8'($urandom);
    dvs_s[u] = 8'($urandom);
    if (e.lat > 1)
      check_eq("result_kept_on_accept", {24'd0, q_s[u]}, {24'd0, last_q[u]});
    wait_drain();
    @(negedge clk);
    if (chk_busy)
      check_eq("busy_cycles", busy_cnt[u], (b == 0) ? 0 : ((u == 0) ? 8 : 4));
  endtask

  initial begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; dvd_s[u] = '0; dvs_s[u] = '0;
      done_prev[u] = 1'b0; busy_cnt[u] = 0;
      last_q[u] = '0; last_r[u] = '0; last_dz[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("reset_busy", {31'd0, busy_s[u]}, 32'd0);
      check_eq("reset_done", {31'd0, done_s[u]}, 32'd0);
      check_eq("reset_quotient", {24'd0, q_s[u]}, 32'd0);
      check_eq("reset_remainder", {24'd0, r_s[u]}, 32'd0);
      check_eq("reset_div_by_zero", {31'd0, dz_s[u]}, 32'd0);
    end
    rst_n = 1'b1;

    run_op(0, 8'd200, 8'd7, 1'b1);
    run_op(0, 8'd255, 8'd1, 1'b1);
    run_op(0, 8'd5,   8'd9, 1'b1);
    run_op(0, 8'd255, 8'd255, 1'b1);
    run_op(0, 8'd0,   8'd3, 1'b1);
    run_op(0, 8'd77,  8'd0, 1'b1);

    // start held high with scrambled operands from acceptance through DONE
    @(negedge clk);
    e = model(0, 8'd100, 8'd3);
    e.acc = cyc + 1;
    start_s[0] = 1'b1; dvd_s[0] = 8'd100; dvs_s[0] = 8'd3;
    sb.push_back(e);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      dvd_s[0] = 8'($urandom);
      dvs_s[0] = 8'($urandom);
    end
    @(negedge clk);
    check_eq("held_start_idle_busy", {31'd0, busy_s[0]}, 32'd0);
    e = model(0, 8'd9, 8'd2);
    e.acc = cyc + 1;
    dvd_s[0] = 8'd9; dvs_s[0] = 8'd2;
    sb.push_back(e);
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    // reset after four RUN edges of 200/7
    @(negedge clk);
    start_s[0] = 1'b1; dvd_s[0] = 8'd200; dvs_s[0] = 8'd7;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_run_busy", {31'd0, busy_s[0]}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy_s[0]}, 32'd0);
    check_eq("abort_done", {31'd0, done_s[0]}, 32'd0);
    check_eq("abort_quotient", {24'd0, q_s[0]}, 32'd0);
    check_eq("abort_remainder", {24'd0, r_s[0]}, 32'd0);
    check_eq("abort_div_by_zero", {31'd0, dz_s[0]}, 32'd0);
    rst_n = 1'b1;
    last_q[0] = '0; last_r[0] = '0; last_dz[0] = 1'b0;
    last_q[1] = '0; last_r[1] = '0; last_dz[1] = 1'b0;
    repeat (10) @(negedge clk);
    run_op(0, 8'd50, 8'd6, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(1, 8'(a), 8'(b), (a == b));
      end
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
